i_cache_assoc: RTL and testbench

- Parametrised N-way set-associative instruction cache with its own miss-handling FSM and refill handshake toward IRAM.
- Sits between the fetch unit's PC and IRAM.
- Hits are returned in the same cycle; on a miss it stalls fetch, requests the aligned block, installs it with per-set round-robin replacement, then replays the lookup.
- Supports whole-cache flush (valid-bit clear).

---
 rtl/icache_pkg.sv | 30 +++
 rtl/i_cache_assoc_if.sv | 26 ++
 rtl/icache_repl.sv | 44 ++++
 rtl/i_cache_assoc.sv | 167 ++++++++++++++++
 tb/tb_i_cache_assoc.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_pkg.sv
// Shared types and width helpers for the set-associative instruction cache.
package icache_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_e;

  function automatic int offset_w(input int block_w);
    return $clog2(block_w / 8);
  endfunction

  function automatic int index_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int pc_w, input int sets, input int block_w);
    return pc_w - index_w(sets) - offset_w(block_w);
  endfunction

  function automatic int words_per_block(input int block_w);
    return block_w / 32;
  endfunction

  // Block storage keeps words in memory byte order; fetch wants them reversed.
  function automatic logic [31:0] byte_rev(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/i_cache_assoc_if.sv
// Refill handshake between the instruction cache (master) and IRAM (slave).
interface i_cache_assoc_if #(
  parameter int PC_W    = 32,
  parameter int BLOCK_W = 128
);

  logic               mem_req;
  logic [PC_W-1:0]    mem_addr;
  logic               mem_valid;
  logic [BLOCK_W-1:0] mem_block;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_valid,
    input  mem_block
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_valid,
    output mem_block
  );

endinterface

// File: rtl/icache_repl.sv
// Per-set victim selection: lowest invalid way first, otherwise a round-robin
// pointer that advances only when a full set is refilled.
module icache_repl
  import icache_pkg::*;
#(
  parameter int SETS = 16,
  parameter int WAYS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [index_w(SETS)-1:0]     set,
  input  logic [WAYS-1:0]              valid_vec,
  input  logic                         advance,
  output logic [$clog2(WAYS)-1:0]      victim
);

  localparam int WAY_W = $clog2(WAYS);

  logic [WAY_W-1:0] ptr [SETS];
  logic             found_invalid;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the loop can leave it unassigned and infer a latch.
  always_comb begin
    victim        = ptr[set];
    found_invalid = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found_invalid && !valid_vec[w]) begin
        victim        = WAY_W'(w);
        found_invalid = 1'b1;
      end
    end
  end

  // WAYS is a power of two, so the natural wrap of the pointer is modulo WAYS.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) ptr[s] <= '0;
    end else if (advance && (&valid_vec)) begin
      ptr[set] <= ptr[set] + 1'b1;
    end
  end

endmodule

// File: rtl/i_cache_assoc.sv
// N-way set-associative instruction cache with a two-state refill FSM.
// Optional ICACHE_PERF_EN adds saturating hit/miss counters.
module i_cache_assoc
  import icache_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int BLOCK_W = 128,
  parameter int SETS    = 16,
  parameter int WAYS    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req,
  input  logic [PC_W-1:0] pc,
  input  logic            flush,
  output logic            hit,
  output logic [31:0]     instr,
  output logic            stall,
  i_cache_assoc_if.master mem
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]     hit_cnt,
  output logic [31:0]     miss_cnt
`endif
);

  localparam int OFFSET_W = offset_w(BLOCK_W);
  localparam int INDEX_W  = index_w(SETS);
  localparam int TAG_W    = tag_w(PC_W, SETS, BLOCK_W);
  localparam int WSEL_W   = OFFSET_W - 2;
  localparam int WAY_W    = $clog2(WAYS);

  // Address split of the incoming fetch PC.
  logic [TAG_W-1:0]   pc_tag;
  logic [INDEX_W-1:0] pc_index;
  logic [WSEL_W-1:0]  pc_word;
  logic               unused_pc_bits;

  assign pc_tag         = pc[PC_W-1 -: TAG_W];
  assign pc_index       = pc[OFFSET_W +: INDEX_W];
  assign pc_word        = pc[2 +: WSEL_W];
  assign unused_pc_bits = ^pc[1:0];

  // Line storage.
  logic [TAG_W-1:0]   tag_mem  [SETS][WAYS];
  logic [BLOCK_W-1:0] data_mem [SETS][WAYS];
  logic [WAYS-1:0]    valid    [SETS];

  // FSM and miss registers.
  state_e             state, state_next;
  logic [TAG_W-1:0]   miss_tag;
  logic [INDEX_W-1:0] miss_index;
  logic               miss_latch;
  logic               install;
  logic [WAY_W-1:0]   victim;

  // Lookup; scanning from the top down lets the lowest matching way win.
  logic               match_any;
  logic [WAY_W-1:0]   match_way;
  logic [BLOCK_W-1:0] hit_block;
  logic [31:0]        sel_word;

  always_comb begin
    match_any = 1'b0;
    match_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid[pc_index][w] && (tag_mem[pc_index][w] == pc_tag)) begin
        match_any = 1'b1;
        match_way = WAY_W'(w);
      end
    end
  end

  assign hit_block = data_mem[pc_index][match_way];
  assign sel_word  = hit_block[32*pc_word +: 32];

  assign hit   = (state == IDLE) && req && match_any;
  assign instr = hit ? byte_rev(sel_word) : 32'h0;
  assign stall = ((state == IDLE) && req && !match_any) || (state == REFILL);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    miss_latch = 1'b0;
    install    = 1'b0;
    case (state)
      IDLE: begin
        if (req && !match_any) begin
          miss_latch = 1'b1;
          state_next = REFILL;
        end
      end
      REFILL: begin
        // A flush in the same cycle as the data discards the block.
        if (mem.mem_valid) begin
          install    = !flush;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      miss_tag   <= '0;
      miss_index <= '0;
    end else if (miss_latch) begin
      miss_tag   <= pc_tag;
      miss_index <= pc_index;
    end
  end

  assign mem.mem_req  = (state == REFILL);
  assign mem.mem_addr = (state == REFILL) ? {miss_tag, miss_index, {OFFSET_W{1'b0}}}
                                          : '0;

  icache_repl #(
    .SETS (SETS),
    .WAYS (WAYS)
  ) u_repl (
    .clk       (clk),
    .rst       (rst),
    .set       (miss_index),
    .valid_vec (valid[miss_index]),
    .advance   (install),
    .victim    (victim)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) valid[s] <= '0;
    end else if (flush) begin
      for (int s = 0; s < SETS; s++) valid[s] <= '0;
    end else if (install) begin
      valid[miss_index][victim] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays are deliberately not reset; the valid bits gate
  // every use, and leaving them reset-free lets them map onto plain RAM.
  always_ff @(posedge clk) begin
    if (install) begin
      tag_mem[miss_index][victim]  <= miss_tag;
      data_mem[miss_index][victim] <= mem.mem_block;
    end
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit && !(&hit_cnt))         hit_cnt  <= hit_cnt + 32'd1;
      if (miss_latch && !(&miss_cnt)) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_i_cache_assoc.sv
// Directed plus randomized bench for i_cache_assoc against a set/way reference model.
module tb_i_cache_assoc;

  localparam int SETS = 16;
  localparam int WAYS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [31:0] pc;
  logic        flush;
  logic        hit;
  logic [31:0] instr;
  logic        stall;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  i_cache_assoc_if #(.PC_W(32), .BLOCK_W(128)) mem_if ();

  i_cache_assoc #(
    .PC_W    (32),
    .BLOCK_W (128),
    .SETS    (SETS),
    .WAYS    (WAYS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .pc       (pc),
    .flush    (flush),
    .hit      (hit),
    .instr    (instr),
    .stall    (stall),
    .mem      (mem_if)
`ifdef ICACHE_PERF_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: contents of each set, plus round-robin pointer per set.
  bit           m_val [SETS][WAYS];
  logic [23:0]  m_tag [SETS][WAYS];
  logic [127:0] m_blk [SETS][WAYS];
  int           m_ptr [SETS];
  int unsigned  m_hits, m_misses;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int set_of(input logic [31:0] a);
    return int'(a[7:4]);
  endfunction

  function automatic logic [31:0] block_base(input logic [31:0] a);
    return {a[31:4], 4'h0};
  endfunction

  function automatic logic [127:0] mem_fn(input logic [31:0] a);
    logic [31:0] b;
    b = block_base(a);
    return {b ^ 32'hC3C3_0003, b ^ 32'h8181_0002, ~b, b ^ 32'h5A5A_0000};
  endfunction

  function automatic logic [31:0] exp_instr(input logic [127:0] blk, input logic [31:0] a);
    logic [31:0] w, r;
    w = blk[32*a[3:2] +: 32];
    r = {<<8{w}};
    return r;
  endfunction

  task automatic model_lookup(input logic [31:0] a, output bit h, output int way);
    int s;
    s = set_of(a);
    h = 1'b0;
    way = 0;
    for (int w = 0; w < WAYS; w++) begin
      if (!h && m_val[s][w] && m_tag[s][w] == a[31:8]) begin
        h = 1'b1;
        way = w;
      end
    end
  endtask

  task automatic model_install(input logic [31:0] a, input logic [127:0] blk);
    int s, v;
    s = set_of(a);
    v = -1;
    for (int w = 0; w < WAYS; w++) if (v < 0 && !m_val[s][w]) v = w;
    if (v < 0) begin
      v = m_ptr[s];
      m_ptr[s] = (m_ptr[s] + 1) % WAYS;
    end
    m_val[s][v] = 1'b1;
    m_tag[s][v] = a[31:8];
    m_blk[s][v] = blk;
  endtask

  task automatic model_flush();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) m_val[s][w] = 1'b0;
  endtask

  task automatic model_reset();
    model_flush();
    for (int s = 0; s < SETS; s++) m_ptr[s] = 0;
    m_hits = 0;
    m_misses = 0;
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    model_flush();
  endtask

  // Combinational look without letting a miss be taken at the next edge.
  task automatic probe(input logic [31:0] a, output bit obs_hit, output logic [31:0] obs_instr);
    bit eh;
    int ew;
    req = 1'b1;
    pc  = a;
    #1;
    model_lookup(a, eh, ew);
    check("probe_hit", hit, eh);
    check("probe_stall", stall, !eh);
    check("probe_instr", instr, eh ? exp_instr(m_blk[set_of(a)][ew], a) : 32'h0);
    obs_hit   = hit;
    obs_instr = instr;
    req = 1'b0;
    #1;
  endtask

  // Full fetch: hit, or miss -> refill (optionally delayed/flushed/collided) -> replay.
  task automatic access(input logic [31:0] a, input int delay, input bit fl_mid,
                        input bit collide, input logic [127:0] blk, output bit obs_hit);
    bit eh;
    int ew;
    req = 1'b1;
    pc  = a;
    #1;
    model_lookup(a, eh, ew);
    check("acc_hit", hit, eh);
    check("acc_stall", stall, !eh);
    check("acc_instr", instr, eh ? exp_instr(m_blk[set_of(a)][ew], a) : 32'h0);
    check("acc_memreq_idle", mem_if.mem_req, 1'b0);
    obs_hit = hit;
    if (eh) begin
      tick();
      m_hits++;
      req = 1'b0;
    end else begin
      tick();
      m_misses++;
      check("refill_memreq", mem_if.mem_req, 1'b1);
      check("refill_addr", mem_if.mem_addr, block_base(a));
      check("refill_stall", stall, 1'b1);
      for (int i = 0; i < delay; i++) begin
        pc = $urandom;
        if (fl_mid && i == 0) flush = 1'b1;
        #1;
        check("wait_hit", hit, 1'b0);
        check("wait_instr", instr, 32'h0);
        tick();
        if (flush) begin
          flush = 1'b0;
          model_flush();
        end
        check("wait_memreq", mem_if.mem_req, 1'b1);
        check("wait_stall", stall, 1'b1);
      end
      pc = a;
      mem_if.mem_valid = 1'b1;
      mem_if.mem_block = blk;
      flush = collide;
      tick();
      mem_if.mem_valid = 1'b0;
      flush = 1'b0;
      if (collide) model_flush();
      else         model_install(a, blk);
      check("after_memreq", mem_if.mem_req, 1'b0);
      if (collide) begin
        req = 1'b0;
        #1;
        check("collide_hit", hit, 1'b0);
        check("collide_stall", stall, 1'b0);
      end else begin
        #1;
        model_lookup(a, eh, ew);
        check("replay_hit", hit, 1'b1);
        check("replay_instr", instr, exp_instr(blk, a));
        check("replay_stall", stall, 1'b0);
        tick();
        m_hits++;
        req = 1'b0;
      end
    end
  endtask

  initial begin
    bit          h;
    logic [31:0] ins;
    logic [31:0] addr;
    logic [127:0] cold_blk;

    rst = 1'b1;
    req = 1'b0;
    pc = '0;
    flush = 1'b0;
    mem_if.mem_valid = 1'b0;
    mem_if.mem_block = '0;
    model_reset();
    tick();
    tick();
    check("rst_hit", hit, 1'b0);
    check("rst_instr", instr, 32'h0);
    check("rst_stall", stall, 1'b0);
    check("rst_memreq", mem_if.mem_req, 1'b0);
    check("rst_memaddr", mem_if.mem_addr, 32'h0);
`ifdef ICACHE_PERF_EN
    check("rst_hitcnt", hit_cnt, 32'h0);
    check("rst_misscnt", miss_cnt, 32'h0);
`endif
    rst = 1'b0;

    // Cold miss and same-block hit.
    cold_blk = {32'hDEAD_BEEF, 32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC};
    access(32'h0000_1008, 0, 1'b0, 1'b0, cold_blk, h);
    check("cold_first_hit", h, 1'b0);
    probe(32'h0000_1008, h, ins);
    check("cold_instr", ins, 32'h4433_2211);
    access(32'h0000_100C, 0, 1'b0, 1'b0, mem_fn(32'h100C), h);
    check("same_block_hit", h, 1'b1);

    // Flush then re-miss on the same block.
    flush_pulse();
    access(32'h0000_1008, 2, 1'b0, 1'b0, cold_blk, h);
    check("flush_remiss", h, 1'b0);

    // Set conflict: five blocks into set 0.
    flush_pulse();
    for (int i = 0; i < 5; i++) begin
      addr = 32'(i) << 8;
      access(addr, i % 3, 1'b0, 1'b0, mem_fn(addr), h);
    end
    probe(32'h0000_0000, h, ins);
    check("conflict_evicted", h, 1'b0);
    probe(32'h0000_0104, h, ins);
    check("conflict_kept", h, 1'b1);

    // Flush colliding with refill data.
    access(32'h0000_2000, 1, 1'b0, 1'b1, mem_fn(32'h2000), h);
    access(32'h0000_2000, 0, 1'b0, 1'b0, mem_fn(32'h2000), h);
    check("collide_remiss", h, 1'b0);

    // Reset in the middle of a refill, then a late mem_valid.
    flush_pulse();
    req = 1'b1;
    pc  = 32'h0000_2040;
    #1;
    check("rmid_miss", hit, 1'b0);
    tick();
    check("rmid_memreq", mem_if.mem_req, 1'b1);
    rst = 1'b1;
    req = 1'b0;
    tick();
    rst = 1'b0;
    model_reset();
    check("rmid_memreq_drop", mem_if.mem_req, 1'b0);
    check("rmid_memaddr", mem_if.mem_addr, 32'h0);
    mem_if.mem_valid = 1'b1;
    mem_if.mem_block = mem_fn(32'h2040);
    tick();
    mem_if.mem_valid = 1'b0;
    check("late_valid_memreq", mem_if.mem_req, 1'b0);
    check("late_valid_stall", stall, 1'b0);
    probe(32'h0000_2040, h, ins);
    check("rmid_remiss", h, 1'b0);

    // Two misses (each replays as a hit) plus one plain hit.
    access(32'h0000_3000, 0, 1'b0, 1'b0, mem_fn(32'h3000), h);
    access(32'h0000_3010, 1, 1'b0, 1'b0, mem_fn(32'h3010), h);
    access(32'h0000_3004, 0, 1'b0, 1'b0, mem_fn(32'h3004), h);
    check("perf_plain_hit", h, 1'b1);
`ifdef ICACHE_PERF_EN
    check("perf_hit_cnt", hit_cnt, 32'd3);
    check("perf_miss_cnt", miss_cnt, 32'd2);
`endif

    // Randomized traffic over a few sets and tags to force reuse and eviction.
    for (int n = 0; n < 150; n++) begin
      logic [23:0] t;
      logic [3:0]  ix;
      logic [1:0]  wd;
      logic [1:0]  lo;
      t  = 24'($urandom_range(0, 5));
      ix = 4'($urandom_range(0, 3));
      wd = 2'($urandom_range(0, 3));
      lo = 2'($urandom);
      addr = {t, ix, wd, lo};
      if ($urandom_range(0, 19) == 0) flush_pulse();
      access(addr, $urandom_range(0, 3), $urandom_range(0, 9) == 0,
             $urandom_range(0, 14) == 0, mem_fn(addr), h);
    end
`ifdef ICACHE_PERF_EN
    check("rand_hit_cnt", hit_cnt, 32'(m_hits));
    check("rand_miss_cnt", miss_cnt, 32'(m_misses));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
